// File: rtl/multi_enemy_hit_judge.sv
// Bullet-vs-enemy hit judge for N_ENEMY channels.
// Each enemy carries health, a hitbox around its registered position and an
// ALIVE/BOOM/DEAD lifecycle. At most one hit per cycle; the lowest index wins.
// Optional feature: define HIT_SCORE_EN to add a saturating 16-bit score output.
module multi_enemy_hit_judge #(
    parameter int unsigned N_ENEMY  = 4,
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned HP_W     = 3,
    parameter int unsigned Y_OFFSET = 480,
    parameter int unsigned BOX_XL   = 10,
    parameter int unsigned BOX_XR   = 50,
    parameter int unsigned BOX_YT   = 50,
    parameter int unsigned BOX_YB   = 40,
    parameter int unsigned BOOM_CYC = 16,
    localparam int unsigned IDX_W   = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic [N_ENEMY*HP_W-1:0]     init_hp,
    input  logic [N_ENEMY*COORD_W-1:0]  ep_x,
    input  logic [N_ENEMY*COORD_W-1:0]  ep_y,
    input  logic [N_ENEMY-1:0]          enemy_en,
    input  logic [COORD_W-1:0]          b_x,
    input  logic [COORD_W-1:0]          b_y,
    input  logic                        b_valid,
    output logic                        bullet_consume,
    output logic                        hit,
    output logic [IDX_W-1:0]            hit_idx,
    output logic [N_ENEMY*HP_W-1:0]     hp_out,
    output logic [N_ENEMY-1:0]          boom,
    output logic [N_ENEMY-1:0]          dead
`ifdef HIT_SCORE_EN
    ,
    output logic [15:0]                 score
`endif
);

    // Two guard bits so box edges below zero or past 2^COORD_W never wrap.
    localparam int unsigned CW    = COORD_W + 2;
    localparam int unsigned CNT_W = (BOOM_CYC > 1) ? $clog2(BOOM_CYC) : 1;

    localparam logic signed [CW-1:0] XL    = CW'(BOX_XL);
    localparam logic signed [CW-1:0] XR    = CW'(BOX_XR);
    localparam logic signed [CW-1:0] YT    = CW'(BOX_YT);
    localparam logic signed [CW-1:0] YB    = CW'(BOX_YB);
    localparam logic [CW-1:0]        Y_OFS = CW'(Y_OFFSET);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(BOOM_CYC - 1);

    typedef enum logic [1:0] {StAlive, StBoom, StDead} state_t;

    logic signed [CW-1:0] ex_q [N_ENEMY];
    logic signed [CW-1:0] ey_q [N_ENEMY];
    logic [N_ENEMY-1:0]   en_q;
    logic [HP_W-1:0]      hp_q [N_ENEMY];
    state_t               state_q [N_ENEMY];
    logic [CNT_W-1:0]     cnt_q [N_ENEMY];
    logic                 armed_q;

    logic signed [CW-1:0] bx_s;
    logic signed [CW-1:0] by_s;
    logic [N_ENEMY-1:0]   match;
    logic                 match_any;
    logic [IDX_W-1:0]     win_idx;
    logic                 hit_now;

    assign bx_s    = $signed({2'b00, b_x});
    assign by_s    = $signed({2'b00, b_y});
    // A simultaneous load discards the hit entirely.
    assign hit_now = match_any && !load;

    // Register enemy positions (y pre-offset) and enables one cycle ahead of the compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ENEMY; i++) begin
                ex_q[i] <= '0;
                ey_q[i] <= '0;
            end
            en_q <= '0;
        end else begin
            for (int i = 0; i < N_ENEMY; i++) begin
                ex_q[i] <= $signed({2'b00, ep_x[i*COORD_W +: COORD_W]});
                ey_q[i] <= $signed({2'b00, ep_y[i*COORD_W +: COORD_W]} + Y_OFS);
            end
            en_q <= enemy_en;
        end
    end

    // Per-enemy hitbox test against the live bullet.
    always_comb begin
        match = '0;
        for (int i = 0; i < N_ENEMY; i++) begin
            match[i] = b_valid && armed_q && en_q[i] && (state_q[i] == StAlive) &&
                       (bx_s >= ex_q[i] - XL) && (bx_s < ex_q[i] + XR) &&
                       (by_s > ey_q[i] - YT) && (by_s < ey_q[i] + YB);
        end
    end

    // Lowest matching index wins.
    always_comb begin
        match_any = 1'b0;
        win_idx   = '0;
        for (int i = N_ENEMY - 1; i >= 0; i--) begin
            if (match[i]) begin
                match_any = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end

    // Per-enemy health and ALIVE/BOOM/DEAD lifecycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ENEMY; i++) begin
                hp_q[i]    <= '0;
                state_q[i] <= StDead;
                cnt_q[i]   <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < N_ENEMY; i++) begin
                hp_q[i]    <= init_hp[i*HP_W +: HP_W];
                state_q[i] <= (init_hp[i*HP_W +: HP_W] != '0) ? StAlive : StDead;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_ENEMY; i++) begin
                case (state_q[i])
                    StAlive: begin
                        // ALIVE implies hp != 0, so this decrement cannot underflow.
                        if (hit_now && (win_idx == IDX_W'(i))) begin
                            hp_q[i] <= hp_q[i] - HP_W'(1);
                            if (hp_q[i] == HP_W'(1)) begin
                                state_q[i] <= StBoom;
                                cnt_q[i]   <= '0;
                            end
                        end
                    end
                    StBoom: begin
                        if (cnt_q[i] == CNT_LAST) begin
                            state_q[i] <= StDead;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                        end
                    end
                    StDead:  ;
                    default: state_q[i] <= StDead;
                endcase
            end
        end
    end

    // Hit pulses and the one-hit-per-bullet arming flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit            <= 1'b0;
            bullet_consume <= 1'b0;
            hit_idx        <= '0;
            armed_q        <= 1'b1;
        end else begin
            hit            <= hit_now;
            bullet_consume <= hit_now;
            if (hit_now) begin
                hit_idx <= win_idx;
                armed_q <= 1'b0;
            end else if (!b_valid) begin
                armed_q <= 1'b1;
            end
        end
    end

    // Pack health and decode lifecycle flags.
    always_comb begin
        hp_out = '0;
        boom   = '0;
        dead   = '0;
        for (int i = 0; i < N_ENEMY; i++) begin
            hp_out[i*HP_W +: HP_W] = hp_q[i];
            boom[i]                = (state_q[i] == StBoom);
            dead[i]                = (state_q[i] == StDead);
        end
    end

`ifdef HIT_SCORE_EN
    logic        kill;
    logic [16:0] score_sum;

    assign kill = hit_now && (hp_q[win_idx] == HP_W'(1));

    // One point per hit, four more for the killing blow.
    always_comb begin
        score_sum = {1'b0, score} + (kill ? 17'd5 : 17'd1);
    end

    // Saturating score; deliberately untouched by load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score <= '0;
        end else if (hit_now) begin
            score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_multi_enemy_hit_judge.sv
// Directed bench for multi_enemy_hit_judge (default parameters).
// Covers score checks too when built with HIT_SCORE_EN.
module tb_multi_enemy_hit_judge;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [11:0] init_hp;
    logic [39:0] ep_x;
    logic [39:0] ep_y;
    logic [3:0]  enemy_en;
    logic [9:0]  b_x;
    logic [9:0]  b_y;
    logic        b_valid;
    logic        bullet_consume;
    logic        hit;
    logic [1:0]  hit_idx;
    logic [11:0] hp_out;
    logic [3:0]  boom;
    logic [3:0]  dead;
`ifdef HIT_SCORE_EN
    logic [15:0] score;
`endif

    int nvec  = 0;
    int nfail = 0;
    int hits;
    int cons;
    int boomcnt;

    multi_enemy_hit_judge dut (
        .clk            (clk),
        .rst            (rst),
        .load           (load),
        .init_hp        (init_hp),
        .ep_x           (ep_x),
        .ep_y           (ep_y),
        .enemy_en       (enemy_en),
        .b_x            (b_x),
        .b_y            (b_y),
        .b_valid        (b_valid),
        .bullet_consume (bullet_consume),
        .hit            (hit),
        .hit_idx        (hit_idx),
        .hp_out         (hp_out),
        .boom           (boom),
        .dead           (dead)
`ifdef HIT_SCORE_EN
        ,
        .score          (score)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bullet shot, then a re-arm cycle with b_valid low.
    task automatic probe(input logic [9:0] bx, input logic [9:0] by, input logic exp_hit,
                         input string tag);
        b_x     = bx;
        b_y     = by;
        b_valid = 1'b1;
        tick();
        check(tag, 32'(hit), 32'(exp_hit));
        b_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        init_hp  = '0;
        ep_x     = '0;
        ep_y     = '0;
        enemy_en = '0;
        b_x      = '0;
        b_y      = '0;
        b_valid  = 1'b0;
        #12;
        check("rst_hp",   32'(hp_out), 32'h0);
        check("rst_dead", 32'(dead), 32'hF);
        check("rst_boom", 32'(boom), 32'h0);
        check("rst_hit",  32'({hit, bullet_consume, hit_idx}), 32'h0);
        rst = 1'b0;

        // e0 at (100,0); e1/e2 overlapping at (300,200); e3 far away.
        ep_x     = {10'd800, 10'd300, 10'd300, 10'd100};
        ep_y     = {10'd300, 10'd200, 10'd200, 10'd0};
        enemy_en = 4'hF;
        init_hp  = 12'o3333;
        load     = 1'b1;
        tick();
        load = 1'b0;
        check("load_hp",   32'(hp_out), 32'(12'o3333));
        check("load_dead", 32'(dead), 32'h0);

        // Bullet held valid 5 cycles: exactly one hit.
        b_x = 10'd120; b_y = 10'd500; b_valid = 1'b1;
        hits = 0; cons = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) check("first_idx", 32'(hit_idx), 32'h0);
            hits += int'(hit);
            cons += int'(bullet_consume);
        end
        check("held_hits", 32'(hits), 32'd1);
        check("held_cons", 32'(cons), 32'd1);
        check("held_hp",   32'(hp_out), 32'(12'o3332));

        // Drop b_valid one cycle to re-arm, then fire again.
        b_valid = 1'b0;
        tick();
        check("rearm_nohit", 32'(hit), 32'h0);
        b_valid = 1'b1;
        tick();
        check("rearm_hit", 32'(hit), 32'h1);
        check("rearm_hp",  32'(hp_out), 32'(12'o3331));
        b_valid = 1'b0;
        tick();

        // Overlap of e1 and e2: lowest index wins.
        b_x = 10'd320; b_y = 10'd700; b_valid = 1'b1;
        tick();
        check("ovl_hit", 32'(hit), 32'h1);
        check("ovl_idx", 32'(hit_idx), 32'h1);
        check("ovl_hp",  32'(hp_out), 32'(12'o3321));
        b_valid = 1'b0;
        tick();
        check("ovl_after", 32'(hit), 32'h0);

        // Kill e0 (hp 1): 16 cycles of boom then dead.
        b_x = 10'd120; b_y = 10'd500; b_valid = 1'b1;
        tick();
        check("kill_hit", 32'({hit, bullet_consume}), 32'h3);
        check("kill_hp",  32'(hp_out), 32'(12'o3320));
        b_valid = 1'b0;
        boomcnt = int'(boom[0]);
        for (int i = 0; i < 20; i++) begin
            tick();
            boomcnt += int'(boom[0]);
        end
        check("boom_len",  32'(boomcnt), 32'd16);
        check("kill_dead", 32'(dead), 32'h1);
        check("kill_boom", 32'(boom), 32'h0);
`ifdef HIT_SCORE_EN
        // e0 killed by three hits (1+1+5) plus one plain hit on e1.
        check("score", 32'(score), 32'd8);
`endif
        b_valid = 1'b1;
        hits = 0; cons = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            hits += int'(hit);
            cons += int'(bullet_consume);
        end
        check("dead_nohit", 32'(hits + cons), 32'd0);
        b_valid = 1'b0;

        // Hitbox boundaries with X=100, Y=480.
        load = 1'b1;
        tick();
        load = 1'b0;
        probe(10'd90,  10'd500, 1'b1, "bx_90");
        probe(10'd150, 10'd500, 1'b0, "bx_150");
        probe(10'd120, 10'd430, 1'b0, "by_430");
        probe(10'd120, 10'd519, 1'b1, "by_519");
        ep_x[9:0] = 10'd5;
        tick();
        probe(10'd0,   10'd500, 1'b1, "x5_bx0");
        check("bnd_hp", 32'(hp_out), 32'(12'o3330));

        // load with a matching bullet in the same cycle.
        ep_x[9:0] = 10'd100;
        init_hp   = 12'o1234;
        load      = 1'b1;
        tick();
        check("reload_hp", 32'(hp_out), 32'(12'o1234));
        init_hp = 12'o1235;
        b_x = 10'd120; b_y = 10'd500; b_valid = 1'b1;
        tick();
        load = 1'b0;
        check("ldhit_none", 32'({hit, bullet_consume}), 32'h0);
        check("ldhit_hp",   32'(hp_out), 32'(12'o1235));
        tick();
        check("ldhit_armed", 32'(hit), 32'h1);
        check("ldhit_hp2",   32'(hp_out), 32'(12'o1234));

        // Disabled enemy cannot be hit.
        b_valid  = 1'b0;
        enemy_en = 4'b1110;
        tick();
        b_valid = 1'b1;
        hits = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            hits += int'(hit);
        end
        check("en_block", 32'(hits), 32'd0);
        check("en_hp",    32'(hp_out), 32'(12'o1234));
        b_valid  = 1'b0;
        enemy_en = 4'hF;
        tick();

        // Reset in the middle of an explosion.
        init_hp = 12'o0001;
        load    = 1'b1;
        tick();
        load = 1'b0;
        check("zero_dead", 32'(dead), 32'hE);
        b_valid = 1'b1;
        tick();
        check("mb_boom", 32'(boom), 32'h1);
        b_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mb_rst_boom", 32'(boom), 32'h0);
        check("mb_rst_dead", 32'(dead), 32'hF);
        check("mb_rst_hp",   32'(hp_out), 32'h0);
        #1;
        rst = 1'b0;
        tick();
        b_valid = 1'b1;
        hits = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            hits += int'(hit);
        end
        check("post_rst_nohit", 32'(hits), 32'd0);
        check("post_rst_dead",  32'(dead), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
